// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: control path for the 5-stage CPU.
// Decodes the ID opcode into a control bundle and carries it through ID/EX,
// EX/MEM and MEM/WB. It also detects load-use hazards, applies branch
// flushes, produces the EX forwarding selects and counts stall/flush cycles.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   id_op, id_rs/rt/rd        ID-stage opcode and register fields
//   flush                     branch taken in EX, squash the ID instruction
//   stall                     hold PC and IF/ID (combinational)
//   ex_aluop/alusrc/branch    EX-stage controls
//   ex_rs, ex_rt              EX-stage source addresses
//   fwd_a, fwd_b              00 regfile, 10 EX/MEM result, 01 MEM/WB result
//   mem_memread/memwrite      MEM-stage controls
//   wb_regwrite/memtoreg      WB-stage controls
//   wb_wr_addr                WB destination register
//   illegal_op                EX holds the bubble of an undefined opcode
//   stall_cnt, flush_cnt      saturating performance counters
module pipe_ctrl_unit #(
    parameter int OP_W    = 6,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    id_op,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               flush,
    output logic               stall,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               ex_alusrc,
    output logic               ex_branch,
    output logic [REG_AW-1:0]  ex_rs,
    output logic [REG_AW-1:0]  ex_rt,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic               mem_memread,
    output logic               mem_memwrite,
    output logic               wb_regwrite,
    output logic               wb_memtoreg,
    output logic [REG_AW-1:0]  wb_wr_addr,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SUBI  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(20);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(35);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(43);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(4);

    logic [ALUOP_W-1:0] w_aluop;
    logic               w_regdst, w_memread, w_memtoreg, w_memwrite;
    logic               w_alusrc, w_regwrite, w_branch;
    logic               w_valid, w_rt_src;
    logic [REG_AW-1:0]  w_dest;
    logic               w_hazard, w_bubble;

    logic [ALUOP_W-1:0] r_ex_aluop;
    logic               r_ex_alusrc, r_ex_branch, r_ex_memread, r_ex_memwrite;
    logic               r_ex_regwrite, r_ex_memtoreg, r_illegal;
    logic [REG_AW-1:0]  r_ex_rs, r_ex_rt, r_ex_dest;
    logic               r_mem_memread, r_mem_memwrite, r_mem_regwrite, r_mem_memtoreg;
    logic [REG_AW-1:0]  r_mem_dest;
    logic               r_wb_regwrite, r_wb_memtoreg;
    logic [REG_AW-1:0]  r_wb_dest;
    logic [CNT_W-1:0]   r_stall_cnt, r_flush_cnt;

    always_comb begin
        w_aluop    = '0;
        w_regdst   = 1'b0;
        w_memread  = 1'b0;
        w_memtoreg = 1'b0;
        w_memwrite = 1'b0;
        w_alusrc   = 1'b0;
        w_regwrite = 1'b0;
        w_branch   = 1'b0;
        w_valid    = 1'b1;
        w_rt_src   = 1'b0;
        case (id_op)
            OP_ADDI: begin
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
            end
            OP_SUBI: begin
                w_aluop    = ALUOP_W'(1);
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
            end
            OP_RTYPE: begin
                w_aluop    = ALUOP_W'(2);
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
                w_rt_src   = 1'b1;
            end
            OP_LW: begin
                w_memread  = 1'b1;
                w_memtoreg = 1'b1;
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
            end
            OP_SW: begin
                w_memwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_rt_src   = 1'b1;
            end
            OP_BEQ: begin
                w_aluop    = ALUOP_W'(1);
                w_branch   = 1'b1;
                w_rt_src   = 1'b1;
            end
            default: w_valid = 1'b0;
        endcase
    end

    assign w_dest = w_regdst ? id_rd : id_rt;

    // rs is a source only for defined opcodes, so an undefined opcode never stalls.
    assign w_hazard = r_ex_memread && (r_ex_dest != '0) &&
                      (((r_ex_dest == id_rs) && w_valid) ||
                       ((r_ex_dest == id_rt) && w_rt_src));
    assign stall    = w_hazard && !flush;
    // Undefined opcodes enter EX as a bubble too; only illegal_op marks them.
    assign w_bubble = flush || w_hazard || !w_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_aluop     <= '0;
            r_ex_alusrc    <= 1'b0;
            r_ex_branch    <= 1'b0;
            r_ex_memread   <= 1'b0;
            r_ex_memwrite  <= 1'b0;
            r_ex_regwrite  <= 1'b0;
            r_ex_memtoreg  <= 1'b0;
            r_ex_rs        <= '0;
            r_ex_rt        <= '0;
            r_ex_dest      <= '0;
            r_illegal      <= 1'b0;
            r_mem_memread  <= 1'b0;
            r_mem_memwrite <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_mem_memtoreg <= 1'b0;
            r_mem_dest     <= '0;
            r_wb_regwrite  <= 1'b0;
            r_wb_memtoreg  <= 1'b0;
            r_wb_dest      <= '0;
            r_stall_cnt    <= '0;
            r_flush_cnt    <= '0;
        end else begin
            if (w_bubble) begin
                r_ex_aluop    <= '0;
                r_ex_alusrc   <= 1'b0;
                r_ex_branch   <= 1'b0;
                r_ex_memread  <= 1'b0;
                r_ex_memwrite <= 1'b0;
                r_ex_regwrite <= 1'b0;
                r_ex_memtoreg <= 1'b0;
                r_ex_rs       <= '0;
                r_ex_rt       <= '0;
                r_ex_dest     <= '0;
            end else begin
                r_ex_aluop    <= w_aluop;
                r_ex_alusrc   <= w_alusrc;
                r_ex_branch   <= w_branch;
                r_ex_memread  <= w_memread;
                r_ex_memwrite <= w_memwrite;
                r_ex_regwrite <= w_regwrite;
                r_ex_memtoreg <= w_memtoreg;
                r_ex_rs       <= id_rs;
                r_ex_rt       <= id_rt;
                r_ex_dest     <= w_dest;
            end
            // A squashed undefined opcode never executed, so it is not flagged.
            r_illegal      <= !w_valid && !flush;

            r_mem_memread  <= r_ex_memread;
            r_mem_memwrite <= r_ex_memwrite;
            r_mem_regwrite <= r_ex_regwrite;
            r_mem_memtoreg <= r_ex_memtoreg;
            r_mem_dest     <= r_ex_dest;

            r_wb_regwrite  <= r_mem_regwrite;
            r_wb_memtoreg  <= r_mem_memtoreg;
            r_wb_dest      <= r_mem_dest;

            if (stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    // EX/MEM result is younger than MEM/WB, so it wins.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (r_mem_regwrite && (r_mem_dest != '0) && (r_mem_dest == r_ex_rs))
            fwd_a = 2'b10;
        else if (r_wb_regwrite && (r_wb_dest != '0) && (r_wb_dest == r_ex_rs))
            fwd_a = 2'b01;
        if (r_mem_regwrite && (r_mem_dest != '0) && (r_mem_dest == r_ex_rt))
            fwd_b = 2'b10;
        else if (r_wb_regwrite && (r_wb_dest != '0) && (r_wb_dest == r_ex_rt))
            fwd_b = 2'b01;
    end

    assign ex_aluop     = r_ex_aluop;
    assign ex_alusrc    = r_ex_alusrc;
    assign ex_branch    = r_ex_branch;
    assign ex_rs        = r_ex_rs;
    assign ex_rt        = r_ex_rt;
    assign mem_memread  = r_mem_memread;
    assign mem_memwrite = r_mem_memwrite;
    assign wb_regwrite  = r_wb_regwrite;
    assign wb_memtoreg  = r_wb_memtoreg;
    assign wb_wr_addr   = r_wb_dest;
    assign illegal_op   = r_illegal;
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipelined control unit for the 5-stage CPU. It decodes the ID-stage opcode into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards (stall plus bubble), applies branch flushes, generates EX-stage forwarding selects, and counts stall and flush cycles. It sits between the IF/ID register and the datapath, and replaces the purely combinational opcode decoder.

## Interface
Parameters:
- OP_W, 6, opcode width
- REG_AW, 5, register address width
- ALUOP_W, 3, ALUOp width (must be ≥3)
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- id_op  in  OP_W  opcode of instruction in ID
- id_rs, id_rt, id_rd  in  REG_AW  ID register fields
- flush  in  1  branch taken (resolved in EX); squash ID instruction
- stall  out  1  hold PC and IF/ID; combinational
- ex_aluop  out  ALUOP_W  EX-stage ALUOp
- ex_alusrc, ex_branch  out  1  EX-stage controls
- ex_rs, ex_rt  out  REG_AW  EX-stage source addresses
- fwd_a, fwd_b  out  2  EX operand select: 00 register file, 10 EX/MEM result, 01 MEM/WB result
- mem_memread, mem_memwrite  out  1  MEM-stage controls
- wb_regwrite, wb_memtoreg  out  1  WB-stage controls
- wb_wr_addr  out  REG_AW  WB destination
- illegal_op  out  1  registered; ID opcode was undefined
- stall_cnt, flush_cnt  out  CNT_W  performance counters

## Operation
- Decode into {ALUOp, RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, Branch}. All fields are 0 for any unlisted opcode.
  - 8 addi: 000_0_0_0_0_1_1_0
  - 9 subi: 001_0_0_0_0_1_1_0
  - 20 R-type: 010_1_0_0_0_0_1_0
  - 35 LW: 000_0_1_1_0_1_1_0
  - 43 SW: 000_0_0_0_1_1_0_0
  - 4 BEQ: 001_0_0_0_0_0_0_1
  - Unlisted opcode: all zero; illegal_op=1 registered into EX with the bubble.
- Destination: RegDst ? id_rd : id_rt, carried EX→MEM→WB.
- rt is a source for R-type, SW and BEQ. rs is a source for all listed opcodes.
- Load-use hazard: ex_memread=1, EX destination ≠0, and the EX destination equals id_rs, or equals id_rt when rt is a source. Then stall=1 and the ID/EX bundle loads a bubble (all zero).
- Flush has priority over stall. flush=1 forces stall=0 and loads a bubble into ID/EX.
- Forwarding, fwd_a (fwd_b identical using ex_rt):
  - 10 if MEM RegWrite=1, MEM destination ≠0 and = ex_rs.
  - Otherwise 01 if WB RegWrite=1, wb_wr_addr ≠0 and = ex_rs.
  - Otherwise 00. MEM stage wins over WB.
- EX/MEM and MEM/WB always advance; stall never freezes them.
- Counters:
  - stall_cnt +1 per cycle with stall=1.
  - flush_cnt +1 per cycle with flush=1.
  - Both saturate at all-ones; no wrap.

## Timing
- Reset (async, immediate):
  - All pipeline registers are bubbles (all zero), including addresses.
  - illegal_op=0, counters=0.
  - stall=0 and fwd_a=fwd_b=00, because they derive from reset state.
- Latency: opcode at ID in cycle N gives EX controls in N+1, MEM controls in N+2, WB controls in N+3.
- stall, fwd_a and fwd_b are combinational from the current ID inputs and registered stages, with no added cycle.
- A load-use stall lasts exactly one cycle. The next cycle the load is in MEM, the hazard clears, and fwd selects 01 once the dependent instruction reaches EX.
- Flush and hazard in the same cycle: bubble inserted, stall=0, stall_cnt unchanged, flush_cnt +1.
- Reset asserted mid-stream: all in-flight controls are discarded immediately. The first post-reset ID opcode appears in EX one edge after rst deasserts.

## Test plan
- Reset, then apply op=8 (addi) with rt=3. Required: ex_aluop=000 and ex_alusrc=1 after 1 edge. After 3 edges: wb_regwrite=1, wb_wr_addr=3, all other outputs 0.
- LW with rt=5, followed by R-type with rs=5. Required: stall=1 for one cycle, bubble in EX, stall_cnt=1. When the R-type reaches EX: fwd_a=01.
- addi with rt=7, followed by R-type with rs=7 and rt=7. Required: fwd_a=fwd_b=10 in the R-type's EX cycle. Repeat with destination 0: required fwd=00.
- Load-use hazard and flush asserted in the same cycle. Required: stall=0, EX bubble, flush_cnt=1, stall_cnt=0.
- Opcode 63. Required: all controls 0 and illegal_op=1 one edge later. Then a valid opcode: required illegal_op=0.
- Assert rst for half a cycle while SW is in MEM. Required: mem_memwrite=0 immediately. With CNT_W=2 and stall forced 5 cycles: required stall_cnt holds at 3.
